// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and assembles one- and two-word (opcode + 16-bit immediate) instructions.
module fetch_unit #(
   parameter int unsigned                ADDR_WIDTH  = 20,
   parameter int unsigned                INSTR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pc_write,
   input  logic                     stall_fetch,
   input  logic                     flush_fetch,
   input  logic [ADDR_WIDTH-1:0]    branch_target,
   output logic [ADDR_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0]   imem_data,
   output logic [INSTR_WIDTH-1:0]   ifid_instr,
   output logic [INSTR_WIDTH-1:0]   ifid_imm,
   output logic [ADDR_WIDTH-1:0]    ifid_pc,
   output logic                     ifid_valid,
   output logic [2:0]               R_dest_fetch,
   output logic [2:0]               R_src_fetch
);

   typedef enum logic {S_FIRST, S_IMM} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [ADDR_WIDTH-1:0]   hold_pc;
   logic [INSTR_WIDTH-1:0]  hold_instr;

   assign imem_addr    = pc;
   assign R_dest_fetch = ifid_instr[10:8];
   assign R_src_fetch  = ifid_instr[7:5];

   // Flush beats stall; stall freezes everything; pc_write=0 freezes PC/FSM but bubbles IF/ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FIRST;
         pc         <= RESET_PC;
         hold_pc    <= '0;
         hold_instr <= '0;
         ifid_instr <= '0;
         ifid_imm   <= '0;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else if (flush_fetch) begin
         state      <= S_FIRST;
         pc         <= branch_target;
         ifid_instr <= '0;
         ifid_imm   <= '0;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else if (stall_fetch) begin
         state <= state;
      end else if (!pc_write) begin
         ifid_instr <= '0;
         ifid_imm   <= '0;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else begin
         pc <= pc + ADDR_WIDTH'(1);
         case (state)
            S_FIRST: begin
               if (imem_data[0]) begin
                  hold_instr <= imem_data;
                  hold_pc    <= pc;
                  state      <= S_IMM;
                  ifid_instr <= '0;
                  ifid_imm   <= '0;
                  ifid_pc    <= '0;
                  ifid_valid <= 1'b0;
               end else begin
                  ifid_instr <= imem_data;
                  ifid_imm   <= '0;
                  ifid_pc    <= pc;
                  ifid_valid <= 1'b1;
               end
            end
            S_IMM: begin
               ifid_instr <= hold_instr;
               ifid_imm   <= imem_data;
               ifid_pc    <= hold_pc;
               ifid_valid <= 1'b1;
               state      <= S_FIRST;
            end
            default: state <= S_FIRST;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each driven cycle pushes the expected IF/ID
// contents and PC, which are popped and compared one clock edge later.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write;
   logic        stall_fetch;
   logic        flush_fetch;
   logic [19:0] branch_target;
   logic [19:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_imm;
   logic [19:0] ifid_pc;
   logic        ifid_valid;
   logic [2:0]  R_dest_fetch;
   logic [2:0]  R_src_fetch;

   logic [15:0] mem [0:255];

   typedef struct {
      logic        valid;
      logic [15:0] instr;
      logic [15:0] imm;
      logic [19:0] pc;
      logic [19:0] addr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   // Only the low 8 address bits select a word, so 0xFFFFF aliases mem[0xFF].
   assign imem_data = mem[imem_addr[7:0]];

   fetch_unit #(.ADDR_WIDTH(20), .INSTR_WIDTH(16), .RESET_PC(20'h0)) dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .stall_fetch(stall_fetch),
      .flush_fetch(flush_fetch), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_data(imem_data), .ifid_instr(ifid_instr),
      .ifid_imm(ifid_imm), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .R_dest_fetch(R_dest_fetch), .R_src_fetch(R_src_fetch)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".valid"}, 32'(ifid_valid), 32'h0);
      check({tag, ".instr"}, 32'(ifid_instr), 32'h0);
      check({tag, ".imm"},   32'(ifid_imm),   32'h0);
      check({tag, ".pc"},    32'(ifid_pc),    32'h0);
      check({tag, ".addr"},  32'(imem_addr),  32'h0);
   endtask

   // Drive inputs at the falling edge, expect results after the next rising edge.
   task automatic step(input string tag, input logic pw, input logic st, input logic fl,
                       input logic [19:0] bt, input logic ev, input logic [15:0] ei,
                       input logic [15:0] eim, input logic [19:0] ep, input logic [19:0] ea);
      exp_t e;
      pc_write      = pw;
      stall_fetch   = st;
      flush_fetch   = fl;
      branch_target = bt;
      sb.push_back('{valid: ev, instr: ei, imm: eim, pc: ep, addr: ea});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         check({tag, ".valid"}, 32'(ifid_valid),   32'(e.valid));
         check({tag, ".instr"}, 32'(ifid_instr),   32'(e.instr));
         check({tag, ".imm"},   32'(ifid_imm),     32'(e.imm));
         check({tag, ".pc"},    32'(ifid_pc),      32'(e.pc));
         check({tag, ".addr"},  32'(imem_addr),    32'(e.addr));
         check({tag, ".rdest"}, 32'(R_dest_fetch), 32'(e.instr[10:8]));
         check({tag, ".rsrc"},  32'(R_src_fetch),  32'(e.instr[7:5]));
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[0]    = 16'h1100;
      mem[1]    = 16'h2201;
      mem[2]    = 16'h00AB;
      mem[3]    = 16'h3300;
      mem[4]    = 16'h4401;
      mem[5]    = 16'h1234;
      mem[8'h40] = 16'h6600;
      mem[8'hFF] = 16'h7760;

      rst = 1'b1; pc_write = 1'b1; stall_fetch = 1'b0; flush_fetch = 1'b0;
      branch_target = 20'h0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      //     tag          pw st fl bt        v  instr     imm       pc        addr
      step("first",      1, 0, 0, 20'h0,    1, 16'h1100, 16'h0,    20'h0,    20'h1);
      step("stall1",     1, 1, 0, 20'h0,    1, 16'h1100, 16'h0,    20'h0,    20'h1);
      step("stall2",     1, 1, 0, 20'h0,    1, 16'h1100, 16'h0,    20'h0,    20'h1);
      step("two_w1",     1, 0, 0, 20'h0,    0, 16'h0,    16'h0,    20'h0,    20'h2);
      step("two_w2",     1, 0, 0, 20'h0,    1, 16'h2201, 16'h00AB, 20'h1,    20'h3);
      step("pcw0",       0, 0, 0, 20'h0,    0, 16'h0,    16'h0,    20'h0,    20'h3);
      step("refetch",    1, 0, 0, 20'h0,    1, 16'h3300, 16'h0,    20'h3,    20'h4);
      step("enter_imm",  1, 0, 0, 20'h0,    0, 16'h0,    16'h0,    20'h0,    20'h5);
      step("flush_imm",  1, 0, 1, 20'h40,   0, 16'h0,    16'h0,    20'h0,    20'h40);
      step("at_target",  1, 0, 0, 20'h0,    1, 16'h6600, 16'h0,    20'h40,   20'h41);
      step("flush_stall",1, 1, 1, 20'hFFFFF,0, 16'h0,    16'h0,    20'h0,    20'hFFFFF);
      step("wrap",       1, 0, 0, 20'h0,    1, 16'h7760, 16'h0,    20'hFFFFF,20'h0);
      step("after_wrap", 1, 0, 0, 20'h0,    1, 16'h1100, 16'h0,    20'h0,    20'h1);
      step("pre_rst_imm",1, 0, 0, 20'h0,    0, 16'h0,    16'h0,    20'h0,    20'h2);

      // Reset asserted mid-S_IMM, checked well before the next rising edge.
      step("load_imm",   1, 0, 0, 20'h0,    1, 16'h2201, 16'h00AB, 20'h1,    20'h3);
      step("enter_imm2", 1, 0, 0, 20'h0,    1, 16'h3300, 16'h0,    20'h3,    20'h4);
      step("enter_imm3", 1, 0, 0, 20'h0,    0, 16'h0,    16'h0,    20'h0,    20'h5);
      #1 rst = 1'b1;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst",   1, 0, 0, 20'h0,    1, 16'h1100, 16'h0,    20'h0,    20'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It is the consumer of the hazard controller's outputs `stall_fetch`, `flush_fetch` and `pc_write`.
- Owns the PC and reads a combinational-read instruction memory.
- Assembles one- and two-word instructions. The second word is a 16-bit immediate.
- Presents the assembled instruction to decode, plus the register fields that the hazard controller compares.

Parameters:
- ADDR_WIDTH, 20, PC / instruction-memory word-address width.
- INSTR_WIDTH, 16, instruction and immediate word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_write  input  1  1 = PC/FSM may advance; 0 = hold PC and FSM.
- stall_fetch  input  1  1 = hold IF/ID register and PC/FSM.
- flush_fetch  input  1  1 = redirect to branch_target; IF/ID becomes bubble.
- branch_target  input  ADDR_WIDTH  redirect address, valid when flush_fetch=1.
- imem_addr  output  ADDR_WIDTH  equals current PC (combinational from PC register).
- imem_data  input  INSTR_WIDTH  word at imem_addr, same cycle.
- ifid_instr  output  INSTR_WIDTH  latched first instruction word.
- ifid_imm  output  INSTR_WIDTH  latched immediate; 0 for one-word instructions.
- ifid_pc  output  ADDR_WIDTH  address of the first word of the latched instruction.
- ifid_valid  output  1  1 = IF/ID holds a real instruction.
- R_dest_fetch  output  3  ifid_instr[10:8], combinational.
- R_src_fetch  output  3  ifid_instr[7:5], combinational.

Behaviour:
- Instruction format:
  - opcode = [15:11], dest = [10:8], src = [7:5].
  - bit[0] = 1 marks a two-word instruction; the next word is the immediate.
- Reset (asynchronous):
  - pc = RESET_PC, state = S_FIRST, hold_instr = 0.
  - ifid_instr = 0, ifid_imm = 0, ifid_pc = 0, ifid_valid = 0.
- Definitions:
  - adv = pc_write & ~stall_fetch & ~flush_fetch.
  - Priority: rst > flush_fetch > hold > adv.
- FSM states are S_FIRST and S_IMM.
- S_FIRST, adv=1:
  - If imem_data[0]=0:
    - IF/ID loads ifid_instr=imem_data, ifid_imm=0, ifid_pc=pc, ifid_valid=1.
    - pc <= pc+1; stay in S_FIRST.
  - If imem_data[0]=1:
    - hold_instr <= imem_data, hold_pc <= pc, pc <= pc+1; go to S_IMM.
    - IF/ID loads a bubble (ifid_valid=0, ifid_instr=0).
- S_IMM, adv=1:
  - IF/ID loads ifid_instr=hold_instr, ifid_imm=imem_data, ifid_pc=hold_pc, ifid_valid=1.
  - pc <= pc+1; go to S_FIRST.
- flush_fetch=1 (regardless of stall_fetch/pc_write):
  - pc <= branch_target, state <= S_FIRST; any partial two-word instruction is dropped.
  - IF/ID <= bubble: all fields 0, ifid_valid=0.
- stall_fetch=1, flush_fetch=0:
  - PC, FSM and the IF/ID register all hold.
- pc_write=0, stall_fetch=0, flush_fetch=0:
  - PC and FSM hold; IF/ID loads a bubble.
- PC arithmetic is modulo 2^ADDR_WIDTH; all-ones+1 wraps to 0.
- Latency: a one-word instruction at address A appears on IF/ID one cycle after the edge where pc=A and adv=1. A two-word instruction takes two advancing cycles.
- Reset mid-S_IMM: immediately returns to S_FIRST at RESET_PC; the partial instruction is discarded.

Test Plan:
- Reset, then run imem[0..2] = 0x1100, 0x2201, 0x00AB, all inputs idle (pc_write=1) ->
  - cycle 1: ifid_instr=0x1100, ifid_pc=0, valid=1, R_dest_fetch=1, R_src_fetch=0.
  - cycle 2: valid=0 (bubble).
  - cycle 3: ifid_instr=0x2201, ifid_imm=0x00AB, ifid_pc=1, valid=1.
  - pc=3.
- stall_fetch=1 for 2 cycles after the first instruction latches -> ifid_instr stays 0x1100, valid stays 1, imem_addr stays 1. Release -> normal progress.
- pc_write=0, stall_fetch=0 for 1 cycle -> IF/ID becomes a bubble (valid=0), pc unchanged. The next cycle fetches the same address.
- flush_fetch=1 with branch_target=0x40 while in S_IMM -> next edge: pc=0x40, state S_FIRST, valid=0, ifid_instr=0. The held two-word instruction never appears.
- flush_fetch=1 and stall_fetch=1 together -> flush wins: pc=branch_target, IF/ID is a bubble.
- Set pc to 0xFFFFF (branch_target) and fetch a one-word instruction -> pc wraps to 0x00000. Asserting rst mid-sequence clears all outputs asynchronously, before the next clock edge.
